// File: rtl/calc_pkg.sv
// Shared calculator definitions: datapath widths, the divider state
// encoding and a two's-complement negation helper.
package calc_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  // Step counter must hold the value DIVIDEND_W itself.
  localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Two's-complement negation at dividend width; narrower operands are
  // zero-extended in and truncated back out, which is exact modulo 2^W.
  function automatic logic [DIVIDEND_W-1:0] twos_neg(input logic [DIVIDEND_W-1:0] v);
    return ~v + DIVIDEND_W'(1);
  endfunction

endpackage

// File: rtl/signed_seq_divider_div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract the
// divisor magnitude from R and keep the difference when it is non-negative.
module div_step
  import calc_pkg::*;
(
  input  logic [DIVISOR_W:0]    r_i,
  input  logic [DIVIDEND_W-1:0] q_i,
  input  logic [DIVISOR_W-1:0]  d_i,
  output logic [DIVISOR_W:0]    r_o,
  output logic [DIVIDEND_W-1:0] q_o
);

  localparam int RW = DIVISOR_W + 1;

  logic [RW-1:0] r_sh;
  logic [RW-1:0] d_inv;
  logic [RW-1:0] diff;
  logic [RW:0]   carry;
  logic          no_borrow;

  // Low RW bits of the shifted partial remainder; the bit shifted out of
  // r_i's MSB only matters for the compare below.
  assign r_sh     = {r_i[RW-2:0], q_i[DIVIDEND_W-1]};
  // R - D computed as R + ~D + 1 through a chain of full-adder cells.
  assign d_inv    = ~{1'b0, d_i};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < RW; i++) begin : g_ripple
    assign diff[i]      = r_sh[i] ^ d_inv[i] ^ carry[i];
    assign carry[i+1]   = (r_sh[i] & d_inv[i]) | (carry[i] & (r_sh[i] ^ d_inv[i]));
  end

  // A shifted-out MSB means the true shifted value exceeds any divisor
  // magnitude; otherwise a carry out of the ripple chain means no borrow.
  assign no_borrow = r_i[RW-1] | carry[RW];

  assign r_o = no_borrow ? diff : r_sh;
  assign q_o = {q_i[DIVIDEND_W-2:0], no_borrow};

endmodule

// File: rtl/signed_seq_divider.sv
// Sequential signed restoring divider: 8-bit dividend / 4-bit divisor,
// one quotient bit per clock, start/busy/done handshake to the controller.
module signed_seq_divider
  import calc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam logic [DIVIDEND_W-1:0] MOST_NEG = {1'b1, {(DIVIDEND_W-1){1'b0}}};

  div_state_t            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DIVISOR_W:0]    rem_acc_q, rem_acc_d;
  logic [DIVIDEND_W-1:0] quo_acc_q, quo_acc_d;
  logic [DIVISOR_W-1:0]  dsr_abs_q, dsr_abs_d;
  logic                  quo_neg_q, quo_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;

  logic [DIVIDEND_W-1:0] dvd_abs;
  logic [DIVISOR_W-1:0]  dsr_abs;
  logic [DIVISOR_W:0]    rem_step;
  logic [DIVIDEND_W-1:0] quo_step;

  // Operand magnitudes; |-128| wraps to 8'h80, which reads as 128 unsigned.
  assign dvd_abs = dividend[DIVIDEND_W-1] ? twos_neg(dividend) : dividend;
  assign dsr_abs = divisor[DIVISOR_W-1]
                 ? DIVISOR_W'(twos_neg(DIVIDEND_W'(divisor)))
                 : divisor;

  div_step u_div_step (
    .r_i (rem_acc_q),
    .q_i (quo_acc_q),
    .d_i (dsr_abs_q),
    .r_o (rem_step),
    .q_o (quo_step)
  );

  // Next-state and next-output logic for the whole divider.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    rem_acc_d   = rem_acc_q;
    quo_acc_d   = quo_acc_q;
    dsr_abs_d   = dsr_abs_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          quo_neg_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
          rem_neg_d = dividend[DIVIDEND_W-1];
          quo_acc_d = dvd_abs;
          dsr_abs_d = dsr_abs;
          rem_acc_d = '0;
          count_d   = CNT_W'(DIVIDEND_W);
          dbz_d     = 1'b0;
          ovf_d     = 1'b0;
          if (divisor == '0) begin
            quotient_d  = '0;
            remainder_d = '0;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else if (dividend == MOST_NEG && divisor == '1) begin
            quotient_d  = MOST_NEG;
            remainder_d = '0;
            ovf_d       = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_acc_d = rem_step;
        quo_acc_d = quo_step;
        count_d   = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d  = quo_neg_q ? twos_neg(quo_acc_q) : quo_acc_q;
        remainder_d = rem_neg_q
                    ? DIVISOR_W'(twos_neg(DIVIDEND_W'(rem_acc_q[DIVISOR_W-1:0])))
                    : rem_acc_q[DIVISOR_W-1:0];
        state_d     = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_acc_q   <= '0;
      quo_acc_q   <= '0;
      dsr_abs_q   <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless
      // of statement order.
      state_q     <= state_d;
      count_q     <= count_d;
      rem_acc_q   <= rem_acc_d;
      quo_acc_q   <= quo_acc_d;
      dsr_abs_q   <= dsr_abs_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Scoreboard bench for signed_seq_divider: stimulus pushes expected results
// computed with plain integer division; a monitor pops on every done pulse.
module tb_signed_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero, overflow;
  logic [7:0] quotient;
  logic [3:0] remainder;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
    int         start_cyc;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   done_cnt = 0;

  signed_seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division truncates toward zero and % takes
  // the sign of the dividend, with the two special cases handled first.
  function automatic exp_t model(input int a, input int b, input int sc);
    exp_t e;
    e.start_cyc = sc;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 0) begin
      e.q = 8'h00; e.r = 4'h0; e.dbz = 1'b1; e.lat = 1;
    end else if (a == -128 && b == -1) begin
      e.q = 8'h80; e.r = 4'h0; e.ovf = 1'b1; e.lat = 1;
    end else begin
      e.q = 8'(a / b); e.r = 4'(a % b); e.lat = 10;
    end
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("quotient",    32'(quotient),    32'(e.q));
        check("remainder",   32'(remainder),   32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        check("overflow",    32'(overflow),    32'(e.ovf));
        check("latency",     32'(cyc - e.start_cyc), 32'(e.lat));
      end
    end
  end

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Called at a negedge: the next rising edge is the start edge.
  task automatic issue(input int a, input int b);
    dividend = 8'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    exp_q.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int a, b, s;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, including the special and extreme operands
    issue(21, -7);    wait_done();
    issue(-22, 5);    wait_done();
    issue(100, -8);   wait_done();
    issue(7, 0);      wait_done();
    issue(-128, -1);  wait_done();
    issue(-128, 0);   wait_done();
    issue(-128, -8);  wait_done();
    issue(-128, 1);   wait_done();
    issue(127, -8);   wait_done();
    issue(-127, 7);   wait_done();
    issue(0, -3);     wait_done();

    // busy visible during a normal run
    issue(50, 3);
    check("busy_in_calc", 32'(busy), 32'd1);
    wait_done();

    // Operand change plus ignored start pulse mid-run
    issue(-5, 2);
    repeat (2) @(negedge clk);
    dividend = 8'd99;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start held through DONE: accepted again in the following IDLE cycle
    dividend = 8'(-100);
    divisor  = 4'd7;
    start    = 1'b1;
    s = cyc + 1;
    exp_q.push_back(model(-100, 7, s));
    exp_q.push_back(model(-100, 7, s + 11));
    while (cyc < s + 11) @(negedge clk);
    start = 1'b0;
    wait_done();

    // Randomised operands
    for (int i = 0; i < 60; i++) begin
      a = $signed(8'($urandom_range(0, 255)));
      b = $signed(4'($urandom_range(0, 15)));
      issue(a, b);
      wait_done();
    end

    // Reset during a run: outputs clear and no done pulse follows
    issue(-77, 6);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_flags", 32'({done, div_by_zero, overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a = done_cnt;
    repeat (15) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - a), 32'd0);

    // A normal division still works after the aborted run
    issue(-22, 5);    wait_done();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
